// File: rtl/tlc_signal_checker.sv
// Passive protocol monitor for the traffic-light lamp buses.
// Every clock it checks the highway and farm codes and latches any violations into sticky flags.
module tlc_signal_checker #(
    parameter int unsigned CNT_W      = 31,
    parameter int unsigned YELLOW_MIN = 300_000_000,
    parameter int unsigned YELLOW_MAX = 500_000_000,
    parameter int unsigned ALLRED_MIN = 100_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    input  logic       farmSensor,
    input  logic       errClear,
    output logic [5:0] errFlags,
    output logic       errPulse,
    output logic [1:0] monState
);

    localparam int unsigned FLAG_W = 6;

    localparam int unsigned F_ILLEGAL = 0;
    localparam int unsigned F_CONFLICT = 1;
    localparam int unsigned F_BAD_SEQ = 2;
    localparam int unsigned F_YELLOW = 3;
    localparam int unsigned F_ALLRED = 4;
    localparam int unsigned F_UNREQ = 5;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] Y_MIN_C   = CNT_W'(YELLOW_MIN);
    localparam logic [CNT_W-1:0] Y_MAX_C   = CNT_W'(YELLOW_MAX);
    localparam logic [CNT_W-1:0] AR_MIN_C  = CNT_W'(ALLRED_MIN);

    typedef enum logic [1:0] {
        RED     = 2'b00,
        YELLOW  = 2'b01,
        GREEN   = 2'b10,
        ILLEGAL = 2'b11
    } lamp_e;

    typedef enum logic [1:0] {
        MON_ALL_RED     = 2'b00,
        MON_HWY_ACTIVE  = 2'b01,
        MON_FARM_ACTIVE = 2'b10,
        MON_CONFLICT    = 2'b11
    } mon_e;

    lamp_e              hwy_prev_q, hwy_prev_d;
    lamp_e              farm_prev_q, farm_prev_d;
    logic [CNT_W-1:0]   hwy_ycnt_q, hwy_ycnt_d;
    logic [CNT_W-1:0]   farm_ycnt_q, farm_ycnt_d;
    logic [CNT_W-1:0]   allred_cnt_q, allred_cnt_d;
    logic               farm_req_q, farm_req_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;
    logic               pulse_q, pulse_d;
    mon_e               mon_q, mon_d;

    lamp_e              hwy_c;
    lamp_e              farm_c;
    logic               hwy_rg_c;
    logic               farm_rg_c;
    logic [FLAG_W-1:0]  det_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Legal per-road steps: hold, G->Y, Y->R, R->G; anything touching 11 is illegal unless held.
    function automatic logic seq_ok(input lamp_e p, input lamp_e c);
        return (p == c) ||
               (p == GREEN  && c == YELLOW) ||
               (p == YELLOW && c == RED)    ||
               (p == RED    && c == GREEN);
    endfunction

    // Short yellow on exit, or overlong yellow exactly when the dwell passes YELLOW_MAX.
    function automatic logic yellow_bad(input lamp_e p, input lamp_e c,
                                        input logic [CNT_W-1:0] cnt);
        return (p == YELLOW && c != YELLOW && cnt < Y_MIN_C) ||
               (c == YELLOW && cnt == Y_MAX_C && cnt != CNT_MAX);
    endfunction

    always_comb begin
        hwy_c       = lamp_e'(highwaySignal);
        farm_c      = lamp_e'(farmSignal);
        hwy_rg_c    = (hwy_prev_q == RED) && (hwy_c == GREEN);
        farm_rg_c   = (farm_prev_q == RED) && (farm_c == GREEN);

        det_c             = '0;
        det_c[F_ILLEGAL]  = (hwy_c == ILLEGAL) || (farm_c == ILLEGAL);
        det_c[F_CONFLICT] = (hwy_c != RED) && (farm_c != RED);
        det_c[F_BAD_SEQ]  = !seq_ok(hwy_prev_q, hwy_c) || !seq_ok(farm_prev_q, farm_c);
        det_c[F_YELLOW]   = yellow_bad(hwy_prev_q, hwy_c, hwy_ycnt_q) ||
                            yellow_bad(farm_prev_q, farm_c, farm_ycnt_q);
        det_c[F_ALLRED]   = (hwy_rg_c || farm_rg_c) && (allred_cnt_q < AR_MIN_C);
        det_c[F_UNREQ]    = farm_rg_c && !farm_req_q;
    end

    always_comb begin
        hwy_prev_d   = hwy_c;
        farm_prev_d  = farm_c;
        hwy_ycnt_d   = '0;
        farm_ycnt_d  = '0;
        allred_cnt_d = '0;
        farm_req_d   = farm_req_q;
        sync1_d      = farmSensor;
        sync2_d      = sync1_q;
        flags_d      = (errClear ? '0 : flags_q) | det_c;
        pulse_d      = |(det_c & ~flags_q);
        mon_d        = MON_ALL_RED;

        if (hwy_c == YELLOW) begin
            hwy_ycnt_d = sat_inc(hwy_ycnt_q);
        end
        if (farm_c == YELLOW) begin
            farm_ycnt_d = sat_inc(farm_ycnt_q);
        end
        if (hwy_c == RED && farm_c == RED) begin
            allred_cnt_d = sat_inc(allred_cnt_q);
        end

        // A granted farm green consumes the request even if the sensor is still asserted.
        if (farm_rg_c) begin
            farm_req_d = 1'b0;
        end else if (sync2_q) begin
            farm_req_d = 1'b1;
        end

        if (det_c[F_CONFLICT]) begin
            mon_d = MON_CONFLICT;
        end else if (hwy_c != RED) begin
            mon_d = MON_HWY_ACTIVE;
        end else if (farm_c != RED) begin
            mon_d = MON_FARM_ACTIVE;
        end
    end

    // All-red counter resets saturated so the first green after reset is never short.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hwy_prev_q   <= RED;
            farm_prev_q  <= RED;
            hwy_ycnt_q   <= '0;
            farm_ycnt_q  <= '0;
            allred_cnt_q <= CNT_MAX;
            farm_req_q   <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            flags_q      <= '0;
            pulse_q      <= 1'b0;
            mon_q        <= MON_ALL_RED;
        end else begin
            hwy_prev_q   <= hwy_prev_d;
            farm_prev_q  <= farm_prev_d;
            hwy_ycnt_q   <= hwy_ycnt_d;
            farm_ycnt_q  <= farm_ycnt_d;
            allred_cnt_q <= allred_cnt_d;
            farm_req_q   <= farm_req_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            flags_q      <= flags_d;
            pulse_q      <= pulse_d;
            mon_q        <= mon_d;
        end
    end

    assign errFlags = flags_q;
    assign errPulse = pulse_q;
    assign monState = mon_q;

endmodule

// File: tb/tb_tlc_signal_checker.sv
// Scoreboard bench for tlc_signal_checker: directed protocol scenarios followed by a random lamp walk,
// each cycle's expected outputs produced by a phase/dwell model of the monitoring rules.
module tb_tlc_signal_checker;

    localparam int unsigned YMIN  = 3;
    localparam int unsigned YMAX  = 5;
    localparam int unsigned ARMIN = 2;
    localparam longint      SAT   = (64'd1 << 31) - 1;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [1:0] highwaySignal = 2'b00;
    logic [1:0] farmSignal = 2'b00;
    logic       farmSensor = 1'b0;
    logic       errClear = 1'b0;
    logic [5:0] errFlags;
    logic       errPulse;
    logic [1:0] monState;

    tlc_signal_checker #(
        .CNT_W      (31),
        .YELLOW_MIN (YMIN),
        .YELLOW_MAX (YMAX),
        .ALLRED_MIN (ARMIN)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .highwaySignal (highwaySignal),
        .farmSignal    (farmSignal),
        .farmSensor    (farmSensor),
        .errClear      (errClear),
        .errFlags      (errFlags),
        .errPulse      (errPulse),
        .monState      (monState)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [5:0] flags;
        logic       pulse;
        logic [1:0] mon;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pulses_seen = 0;

    // Model state: last code per road, length of the current yellow / all-red run, request pipeline.
    int         m_hp, m_fp;
    longint     m_hy, m_fy, m_ar;
    bit         m_req, m_s1, m_s2;
    logic [5:0] m_flags;

    function automatic void model_reset();
        m_hp = 0; m_fp = 0;
        m_hy = 0; m_fy = 0;
        m_ar = SAT;
        m_req = 0; m_s1 = 0; m_s2 = 0;
        m_flags = '0;
    endfunction

    function automatic bit legal_step(input int p, input int c);
        return (p == c) || (p == 2 && c == 1) || (p == 1 && c == 0) || (p == 0 && c == 2);
    endfunction

    function automatic bit yellow_fault(input int p, input int c, input longint run);
        return (p == 1 && c != 1 && run < YMIN) || (c == 1 && run + 1 == YMAX + 1);
    endfunction

    function automatic exp_t model_step(input int h, input int f, input bit sens, input bit clr);
        logic [5:0] det;
        exp_t       e;
        bit         farm_grant;
        det        = '0;
        farm_grant = (m_fp == 0 && f == 2);
        det[0] = (h == 3) || (f == 3);
        det[1] = (h != 0) && (f != 0);
        det[2] = !legal_step(m_hp, h) || !legal_step(m_fp, f);
        det[3] = yellow_fault(m_hp, h, m_hy) || yellow_fault(m_fp, f, m_fy);
        det[4] = ((m_hp == 0 && h == 2) || farm_grant) && (m_ar < ARMIN);
        det[5] = farm_grant && !m_req;
        e.mon   = det[1] ? 2'd3 : (h != 0) ? 2'd1 : (f != 0) ? 2'd2 : 2'd0;
        e.pulse = |(det & ~m_flags);
        m_flags = (clr ? 6'd0 : m_flags) | det;
        e.flags = m_flags;
        m_hy = (h == 1) ? m_hy + 1 : 0;
        m_fy = (f == 1) ? m_fy + 1 : 0;
        m_ar = (h == 0 && f == 0) ? ((m_ar >= SAT) ? SAT : m_ar + 1) : 0;
        if (farm_grant) m_req = 0;
        else if (m_s2)  m_req = 1;
        m_s2 = m_s1;
        m_s1 = sens;
        m_hp = h;
        m_fp = f;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_step(input int h, input int f, input bit sens, input bit clr);
        highwaySignal = 2'(h);
        farmSignal    = 2'(f);
        farmSensor    = sens;
        errClear      = clr;
        sb_q.push_back(model_step(h, f, sens, clr));
    endtask

    task automatic cyc(input int h, input int f, input bit sens = 0, input bit clr = 0);
        @(negedge Clk);
        drive_step(h, f, sens, clr);
        @(posedge Clk);
        #2;
    endtask

    // Monitor: outputs are valid every clock after reset; pop one expectation per edge.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (Rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            if (errPulse) pulses_seen++;
            if ({errFlags, errPulse, monState} !== {e.flags, e.pulse, e.mon}) begin
                miscompares++;
                $display("FAIL scoreboard: got flags=%b pulse=%b mon=%b expected flags=%b pulse=%b mon=%b at %0t",
                         errFlags, errPulse, monState, e.flags, e.pulse, e.mon, $time);
            end
        end
    end

    initial begin
        int h;
        int f;
        int p0;

        model_reset();
        #3;
        check("reset_flags", 32'(errFlags), 32'd0);
        check("reset_pulse", 32'(errPulse), 32'd0);
        check("reset_mon", 32'(monState), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        drive_step(0, 0, 0, 0);
        @(posedge Clk);
        #2;

        // Legal full cycle with an early farm request.
        p0 = pulses_seen;
        for (int i = 0; i < 10; i++) cyc(2, 0, (i == 1), 0);
        for (int i = 0; i < 4; i++) cyc(1, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 2);
        for (int i = 0; i < 4; i++) cyc(0, 1);
        for (int i = 0; i < 2; i++) cyc(0, 0);
        check("legal_flags", 32'(errFlags), 32'd0);
        check("legal_no_pulse", 32'(pulses_seen - p0), 32'd0);

        // Short yellow.
        for (int i = 0; i < 3; i++) cyc(2, 0);
        cyc(1, 0);
        cyc(1, 0);
        cyc(0, 0);
        check("short_y_flags", 32'(errFlags), 32'h08);
        check("short_y_pulse", 32'(errPulse), 32'd1);
        cyc(0, 0);
        check("short_y_pulse_drop", 32'(errPulse), 32'd0);
        cyc(0, 0, 0, 1);
        cyc(0, 0);

        // Overlong yellow flags once at the sixth yellow cycle.
        for (int i = 0; i < 2; i++) cyc(2, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0);
        check("long_y_before", 32'(errFlags), 32'd0);
        cyc(1, 0);
        check("long_y_flags", 32'(errFlags), 32'h08);
        check("long_y_pulse", 32'(errPulse), 32'd1);
        cyc(1, 0);
        check("long_y_single_pulse", 32'(errPulse), 32'd0);
        cyc(0, 0);
        cyc(0, 0, 0, 1);
        check("long_y_cleared", 32'(errFlags), 32'd0);
        cyc(0, 0);

        // Both roads green together, farm without a request.
        cyc(2, 2);
        check("conflict_flags", 32'(errFlags), 32'h22);
        check("conflict_mon", 32'(monState), 32'd3);
        cyc(1, 1);
        cyc(0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0);
        cyc(0, 0);

        // Skipped yellow, then illegal code; clear cannot beat a live violation.
        cyc(2, 0);
        cyc(0, 0);
        check("bad_seq_flags", 32'(errFlags), 32'h04);
        cyc(3, 0);
        check("illegal_flags", 32'(errFlags & 6'h05), 32'h05);
        cyc(3, 0, 0, 1);
        check("clear_vs_detect", 32'(errFlags[0]), 32'd1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0);
        cyc(0, 0);

        // Asynchronous reset in the middle of a yellow phase.
        cyc(2, 0, 1, 0);
        cyc(1, 0);
        cyc(1, 0);
        @(negedge Clk);
        Rst = 1'b0;
        highwaySignal = 2'b00;
        #1;
        check("mid_reset_flags", 32'(errFlags), 32'd0);
        check("mid_reset_pulse", 32'(errPulse), 32'd0);
        check("mid_reset_mon", 32'(monState), 32'd0);
        model_reset();
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        drive_step(2, 0, 0, 0);
        @(posedge Clk);
        #2;
        check("post_reset_green", 32'(errFlags), 32'd0);
        check("post_reset_mon", 32'(monState), 32'd1);

        // Random walk: mostly legal phase advances, occasional arbitrary codes.
        h = 2;
        f = 0;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 12)      h = (h == 2) ? 1 : (h == 1) ? 0 : (h == 0) ? 2 : 0;
            else if (r < 14) h = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 99));
            if (r < 12)      f = (f == 2) ? 1 : (f == 1) ? 0 : (f == 0) ? 2 : 0;
            else if (r < 14) f = int'($urandom_range(0, 3));
            if (h != 0 && f != 0 && $urandom_range(0, 3) != 0) f = 0;
            cyc(h, f, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        end

        @(negedge Clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
